edge_event_arbiter: RTL and testbench

Collects edge events from `N` asynchronous-to-consumer level inputs and hands them, one at a time, to a single shared consumer over a valid/ready handshake. Each input gets its own edge-capture cell and a pending latch. A round-robin scheduler picks which pending event to present next. The block sits between the utility edge detectors and any downstream unit, such as a sequencer or fitness counter, that can accept only one event per cycle.

---
 rtl/util_pkg.sv | 16 +
 rtl/edge_capture_cell.sv | 42 ++++
 rtl/edge_event_arbiter.sv | 82 ++++++++
 tb/tb_edge_event_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/util_pkg.sv
// util_pkg: shared edge-mode, direction and arbiter-state definitions
//    EDGE_MODE_* : edge selection codes for edge capture cells
//    DIR_*       : event direction encoding (1 = rising)
//    arb_state_t : scheduler states
//    wrap_add    : (a + b) mod n for a, b < n
package util_pkg;
   localparam logic [1:0] EDGE_MODE_RISE = 2'd0;
   localparam logic [1:0] EDGE_MODE_FALL = 2'd1;
   localparam logic [1:0] EDGE_MODE_BOTH = 2'd2;
   localparam logic DIR_FALL = 1'b0;
   localparam logic DIR_RISE = 1'b1;
   typedef enum logic {ARB_IDLE, ARB_OFFER} arb_state_t;
   function automatic int wrap_add(input int a, input int b, input int n);
      return (a + b >= n) ? a + b - n : a + b;
   endfunction
endpackage

// File: rtl/edge_capture_cell.sv
// edge_capture_cell: one channel's edge detector with a single-entry pending latch
//    clk, rst (async, active-low), d (level input), clr (pending consumed)
//    pend (event waiting), dir (its direction), drop (edge lost, EDGE_ARB_OVERFLOW_EN only)
module edge_capture_cell import util_pkg::*; #(
   parameter logic       TEMP_INIT = 1'b0,
   parameter logic [1:0] MODE      = EDGE_MODE_BOTH
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   input  logic clr,
   output logic pend,
   output logic dir
`ifdef EDGE_ARB_OVERFLOW_EN
   ,output logic drop
`endif
);
   logic r_prev, r_pend, r_dir;
   logic w_rise, w_fall, w_ev, w_set;
   always_comb begin
      w_rise = d & ~r_prev;
      w_fall = ~d & r_prev;
      w_ev   = (MODE == EDGE_MODE_RISE) ? w_rise : (MODE == EDGE_MODE_FALL) ? w_fall : (w_rise | w_fall);
      // a clear in the same cycle frees the slot, so the new edge takes it
      w_set  = w_ev & (~r_pend | clr);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_prev <= TEMP_INIT;
         r_pend <= 1'b0;
         r_dir  <= DIR_FALL;
      end else begin
         r_prev <= d;
         r_pend <= w_set | (r_pend & ~clr);
         if (w_set) r_dir <= w_rise ? DIR_RISE : DIR_FALL;
      end
   assign pend = r_pend;
   assign dir  = r_dir;
`ifdef EDGE_ARB_OVERFLOW_EN
   assign drop = w_ev & r_pend & ~clr;
`endif
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: round-robin serialiser of per-channel edge events onto one valid/ready port
//    clk, rst (async, active-low), din[N] level inputs
//    ev_valid/ev_ready/ev_chan/ev_dir event handshake, pending[N] debug view
//    overflow: sticky dropped-edge flag, present only with EDGE_ARB_OVERFLOW_EN
module edge_event_arbiter import util_pkg::*; #(
   parameter int         N         = 4,
   parameter logic       TEMP_INIT = 1'b0,
   parameter logic [1:0] MODE      = EDGE_MODE_BOTH,
   localparam int        CW        = ($clog2(N) > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  din,
   output logic          ev_valid,
   input  logic          ev_ready,
   output logic [CW-1:0] ev_chan,
   output logic          ev_dir,
   output logic [N-1:0]  pending
`ifdef EDGE_ARB_OVERFLOW_EN
   ,output logic         overflow
`endif
);
   arb_state_t    r_state;
   logic [CW-1:0] r_chan, r_rr_ptr, w_base, w_sel;
   logic          r_dir, w_found, w_load;
   logic [N-1:0]  w_pend, w_pdir, w_clr;
`ifdef EDGE_ARB_OVERFLOW_EN
   logic [N-1:0]  w_drop;
   logic          r_ovf;
`endif
   for (genvar i = 0; i < N; i++) begin : g_cell
      edge_capture_cell #(.TEMP_INIT(TEMP_INIT), .MODE(MODE)) u_cell (
         .clk  (clk),
         .rst  (rst),
         .d    (din[i]),
         .clr  (w_clr[i]),
         .pend (w_pend[i]),
         .dir  (w_pdir[i])
`ifdef EDGE_ARB_OVERFLOW_EN
         ,.drop(w_drop[i])
`endif
      );
   end
   always_comb begin
      // on a handshake the search already starts past the channel just served
      w_base  = (r_state == ARB_OFFER) ? CW'(wrap_add(int'(r_chan), 1, N)) : r_rr_ptr;
      w_sel   = '0;
      w_found = 1'b0;
      // walk offsets downward so the smallest offset from w_base wins
      for (int k = N - 1; k >= 0; k--)
         if (w_pend[wrap_add(int'(w_base), k, N)]) begin
            w_sel   = CW'(wrap_add(int'(w_base), k, N));
            w_found = 1'b1;
         end
      w_load  = w_found & ((r_state == ARB_IDLE) | ev_ready);
      w_clr   = w_load ? (N'(1) << w_sel) : '0;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state  <= ARB_IDLE;
         r_chan   <= '0;
         r_dir    <= DIR_FALL;
         r_rr_ptr <= '0;
      end else begin
         if (r_state == ARB_OFFER && ev_ready) r_rr_ptr <= w_base;
         if (w_load) begin
            r_state <= ARB_OFFER;
            r_chan  <= w_sel;
            r_dir   <= w_pdir[w_sel];
         end else if (ev_ready) r_state <= ARB_IDLE;
      end
`ifdef EDGE_ARB_OVERFLOW_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_ovf <= 1'b0;
      else if (|w_drop) r_ovf <= 1'b1;
   assign overflow = r_ovf;
`endif
   assign ev_valid = (r_state == ARB_OFFER);
   assign ev_chan  = r_chan;
   assign ev_dir   = r_dir;
   assign pending  = w_pend;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed scenarios plus random traffic against a behavioural model
module tb_edge_event_arbiter;
   localparam int N = 4;
   logic clk = 1'b0, rst = 1'b0, ev_ready = 1'b0, ready_r = 1'b0;
   logic ev_valid, ev_dir, valid_r, dir_r;
   logic [N-1:0] din = '0, din_r = '0, pending, pend_r;
   logic [1:0] ev_chan, chan_r;
`ifdef EDGE_ARB_OVERFLOW_EN
   logic overflow, ovf_r;
`endif
   int checks = 0, errors = 0;
   always #5 clk = ~clk;

   edge_event_arbiter #(.N(N), .TEMP_INIT(1'b0), .MODE(2'd2)) u_dut (
      .clk(clk), .rst(rst), .din(din), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_chan(ev_chan), .ev_dir(ev_dir), .pending(pending)
`ifdef EDGE_ARB_OVERFLOW_EN
      ,.overflow(overflow)
`endif
   );
   edge_event_arbiter #(.N(N), .TEMP_INIT(1'b0), .MODE(2'd0)) u_dut_rise (
      .clk(clk), .rst(rst), .din(din_r), .ev_valid(valid_r), .ev_ready(ready_r),
      .ev_chan(chan_r), .ev_dir(dir_r), .pending(pend_r)
`ifdef EDGE_ARB_OVERFLOW_EN
      ,.overflow(ovf_r)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // behavioural model of the MODE=2 instance: one slot per channel, a pointer, one offered event
   bit [N-1:0] m_pend = '0, m_pdir = '0, m_prev = '0, m_clr;
   bit m_valid = 0, m_dir = 0, m_ovf = 0, found, rise, fall;
   int m_chan = 0, m_ptr = 0, base, sel;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pend = '0; m_pdir = '0; m_prev = '0;
         m_valid = 0; m_dir = 0; m_ovf = 0; m_chan = 0; m_ptr = 0;
      end else begin
         m_clr = '0;
         if (!m_valid || ev_ready) begin
            base = m_valid ? (m_chan + 1) % N : m_ptr;
            if (m_valid) m_ptr = base;
            found = 0;
            for (int k = 0; k < N; k++)
               if (!found && m_pend[(base + k) % N]) begin
                  found = 1;
                  sel = (base + k) % N;
               end
            m_valid = found;
            if (found) begin
               m_chan = sel;
               m_dir = m_pdir[sel];
               m_clr[sel] = 1;
            end
         end
         for (int i = 0; i < N; i++) begin
            rise = din[i] && !m_prev[i];
            fall = !din[i] && m_prev[i];
            if (rise || fall) begin
               if (!m_pend[i] || m_clr[i]) begin
                  m_pend[i] = 1;
                  m_pdir[i] = rise;
               end else m_ovf = 1;
            end else if (m_clr[i]) m_pend[i] = 0;
            m_prev[i] = din[i];
         end
      end
   end

   always @(negedge clk)
      if (rst) begin
         check("m_valid", ev_valid, m_valid);
         check("m_pending", pending, m_pend);
         if (m_valid) begin
            check("m_chan", ev_chan, m_chan);
            check("m_dir", ev_dir, m_dir);
         end
`ifdef EDGE_ARB_OVERFLOW_EN
         check("m_overflow", overflow, m_ovf);
`endif
      end

   task automatic do_reset();
      rst = 1'b0;
      din = '0;
      din_r = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int last;
      int grants;
      din = 4'b0010;
      ev_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rel_valid_e1", ev_valid, 0);
      check("rel_pend_e1", pending, 4'b0010);
      @(negedge clk);
      check("rel_valid_e2", ev_valid, 1);
      check("rel_chan", ev_chan, 1);
      check("rel_dir", ev_dir, 1);
      @(negedge clk);
      check("rel_one_cycle", ev_valid, 0);

      do_reset();
      din = 4'b1101;
      @(negedge clk);
      check("multi_pend", pending, 4'b1101);
      check("multi_idle", ev_valid, 0);
      @(negedge clk);
      check("multi_v0", ev_valid, 1);
      check("multi_c0", ev_chan, 0);
      @(negedge clk);
      check("multi_c2", ev_chan, 2);
      @(negedge clk);
      check("multi_c3", ev_chan, 3);
      @(negedge clk);
      check("multi_done", ev_valid, 0);

      do_reset();
      ev_ready = 1'b0;
      din = 4'b0010;
      @(negedge clk);
      @(negedge clk);
      din = 4'b0000;
      for (int c = 0; c < 5; c++) begin
         check("hold_valid", ev_valid, 1);
         check("hold_chan", ev_chan, 1);
         check("hold_dir", ev_dir, 1);
         @(negedge clk);
      end
      check("hold_pend1", pending[1], 1);
      ev_ready = 1'b1;
      @(negedge clk);
      check("hold_next_chan", ev_chan, 1);
      check("hold_next_dir", ev_dir, 0);
      @(negedge clk);
      check("hold_drained", ev_valid, 0);

      do_reset();
      din_r = 4'b1000;
      @(negedge clk);
      check("rise_pend", pend_r, 4'b1000);
      @(negedge clk);
      check("rise_valid", valid_r, 1);
      check("rise_chan", chan_r, 3);
      din_r = 4'b0000;
      @(negedge clk);
      check("rise_fall_ignored", pend_r, 4'b0000);
      din_r = 4'b1000;
      @(negedge clk);
      check("rise_second", pend_r, 4'b1000);
`ifdef EDGE_ARB_OVERFLOW_EN
      check("rise_ovf0", ovf_r, 0);
`endif
      din_r = 4'b0000;
      @(negedge clk);
      din_r = 4'b1000;
      @(negedge clk);
      check("rise_drop_pend", pend_r, 4'b1000);
      check("rise_drop_chan", chan_r, 3);
      check("rise_drop_dir", dir_r, 1);
`ifdef EDGE_ARB_OVERFLOW_EN
      check("rise_ovf1", ovf_r, 1);
`endif
      ready_r = 1'b1;
      @(negedge clk);
      check("rise_second_offer", valid_r, 1);
      @(negedge clk);
      check("rise_empty", valid_r, 0);
      ready_r = 1'b0;

      do_reset();
      ev_ready = 1'b1;
      last = -1;
      grants = 0;
      for (int c = 0; c < 24; c++) begin
         din = ~din;
         @(negedge clk);
         if (ev_valid) begin
            grants++;
            if (last >= 0) check("fair_order", ev_chan, (last + 1) % N);
            last = int'(ev_chan);
         end else last = -1;
      end
      check("fair_grants", grants, 23);

      do_reset();
      ev_ready = 1'b0;
      din = 4'b0111;
      @(negedge clk);
      @(negedge clk);
      din = 4'b1110;
      @(negedge clk);
      check("rstmid_pend", pending, 4'b1111);
      check("rstmid_offer", ev_valid, 1);
      #2 rst = 1'b0;
      #1;
      check("rstmid_valid", ev_valid, 0);
      check("rstmid_pending", pending, 0);
      din = '0;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("rstmid_quiet", ev_valid, 0);
      end

      do_reset();
      for (int c = 0; c < 400; c++) begin
         din = N'($urandom);
         ev_ready = ($urandom_range(0, 3) != 0);
         if (c == 200) begin
            #2 rst = 1'b0;
            #1 rst = 1'b1;
         end
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
